// File: rtl/game_status_tracker.sv
// Play-state bookkeeping for the game: BCD score/high score, lives, wave, aliens
// remaining, plus the respawn and wave-clear pauses that feed the control FSM and HUD.
module game_status_tracker #(
  parameter int INIT_LIVES        = 3,
  parameter int NUM_ALIENS        = 55,
  parameter int RESPAWN_FRAMES    = 120,
  parameter int WAVE_DELAY_FRAMES = 90
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_tick,
  input  logic        alien_hit,
  input  logic [1:0]  hit_type,
  input  logic        player_hit,
  input  logic        aliens_landed,
  output logic        finished,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic [1:0]  lives,
  output logic [3:0]  wave,
  output logic [5:0]  aliens_left,
  output logic        respawning,
  output logic        wave_clear
);

  typedef enum logic [2:0] {IDLE, ACTIVE, RESPAWN, WAVE_CLEAR, OVER} state_t;

  localparam logic [1:0] LIVES_INIT   = 2'(INIT_LIVES);
  localparam logic [5:0] ALIENS_INIT  = 6'(NUM_ALIENS);
  localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] WAVE_LAST    = 8'(WAVE_DELAY_FRAMES - 1);

  state_t      state, state_d;
  logic [15:0] score_d, high_score_d, points;
  logic [16:0] sum;
  logic [1:0]  lives_d;
  logic [3:0]  wave_d;
  logic [5:0]  aliens_d;
  logic [7:0]  frame_cnt, frame_cnt_d;
  logic        finished_d, respawning_d, wave_clear_d;
  logic        counts_alien;

  // Per-digit BCD add; bit 16 is the carry out of the thousands digit.
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  d;
    logic        c;
    logic [15:0] s;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      c = (d > 5'd9);
      if (c) d = d + 5'd6;
      s[4*i +: 4] = d[3:0];
    end
    return {c, s};
  endfunction

  always_comb begin
    unique case (hit_type)
      2'd0:    points = 16'h0010;
      2'd1:    points = 16'h0020;
      2'd2:    points = 16'h0030;
      default: points = 16'h0100;
    endcase
  end

  assign sum          = bcd_add(score, points);
  assign counts_alien = alien_hit && (hit_type != 2'd3);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case/if tree can leave one unassigned and infer a latch.
    state_d      = state;
    score_d      = score;
    high_score_d = high_score;
    lives_d      = lives;
    wave_d       = wave;
    aliens_d     = aliens_left;

    if (start) begin
      state_d  = ACTIVE;
      score_d  = '0;
      lives_d  = LIVES_INIT;
      wave_d   = 4'd1;
      aliens_d = ALIENS_INIT;
      // A start in the first OVER cycle must not lose the final score.
      if (state == OVER && score > high_score) high_score_d = score;
    end else begin
      if (alien_hit && (state == ACTIVE || state == RESPAWN || state == WAVE_CLEAR))
        score_d = sum[16] ? 16'h9999 : sum[15:0];

      unique case (state)
        IDLE: ;
        ACTIVE, RESPAWN: begin
          if (counts_alien && aliens_left != 6'd0) aliens_d = aliens_left - 6'd1;
          if (state == RESPAWN && frame_tick && frame_cnt == RESPAWN_LAST) state_d = ACTIVE;
          if (state == ACTIVE && player_hit) begin
            lives_d = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
            state_d = (lives_d == 2'd0) ? OVER : RESPAWN;
          end
          // Wave clear loses only to game over.
          if (aliens_d == 6'd0 && aliens_left != 6'd0 && state_d != OVER) state_d = WAVE_CLEAR;
          if (aliens_landed) begin
            state_d = OVER;
            lives_d = 2'd0;
          end
        end
        WAVE_CLEAR: begin
          if (aliens_landed) begin
            state_d = OVER;
            lives_d = 2'd0;
          end else if (frame_tick && frame_cnt == WAVE_LAST) begin
            state_d  = ACTIVE;
            aliens_d = ALIENS_INIT;
            wave_d   = (wave == 4'd15) ? 4'd15 : wave + 4'd1;
          end
        end
        OVER: begin
          // Packed BCD orders the same as plain binary, MS digit first.
          if (score > high_score) high_score_d = score;
        end
        default: state_d = IDLE;
      endcase
    end

    if (start || state_d != state) frame_cnt_d = '0;
    else if (frame_tick)           frame_cnt_d = frame_cnt + 8'd1;
    else                           frame_cnt_d = frame_cnt;

    finished_d   = (state_d == OVER);
    respawning_d = (state_d == RESPAWN);
    wave_clear_d = (state_d == WAVE_CLEAR) && (state != WAVE_CLEAR);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      score       <= '0;
      high_score  <= '0;
      lives       <= '0;
      wave        <= '0;
      aliens_left <= '0;
      frame_cnt   <= '0;
      finished    <= 1'b0;
      respawning  <= 1'b0;
      wave_clear  <= 1'b0;
    end else begin
      state       <= state_d;
      score       <= score_d;
      high_score  <= high_score_d;
      lives       <= lives_d;
      wave        <= wave_d;
      aliens_left <= aliens_d;
      frame_cnt   <= frame_cnt_d;
      finished    <= finished_d;
      respawning  <= respawning_d;
      wave_clear  <= wave_clear_d;
    end
  end

endmodule
